// File: rtl/multi_alarm_clock_ctrl.sv
// multi_alarm_clock_ctrl: HH:MM:SS timekeeper with NUM_ALARMS alarms, button set mode and ring timeout
// Ports: clk, rst (sync, active-high); btn_c/l/r/u/d_i press pulses; alarm_en_i per-alarm arm bits;
//   time_bcd_o HHMM, sec_bcd_o SS, disp_bcd_o time or edited alarm, alarm_sel_o edited/ringing index,
//   mode_led_o one-hot {SET_AM,SET_AH,SET_TM,SET_TH}, ringing_o, ring_blink_o, sec_pulse_o.
// Optional snooze enabled by defining MULTI_ALARM_SNOOZE_EN.
module multi_alarm_clock_ctrl #(
  parameter int NUM_ALARMS = 2,
  parameter int TICK_DIV = 100_000_000,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_c_i,
  input  logic                  btn_l_i,
  input  logic                  btn_r_i,
  input  logic                  btn_u_i,
  input  logic                  btn_d_i,
  input  logic [NUM_ALARMS-1:0] alarm_en_i,
  output logic [15:0]           time_bcd_o,
  output logic [7:0]            sec_bcd_o,
  output logic [15:0]           disp_bcd_o,
  output logic [AW-1:0]         alarm_sel_o,
  output logic [3:0]            mode_led_o,
  output logic                  ringing_o,
  output logic                  ring_blink_o,
  output logic                  sec_pulse_o
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [AW-1:0] LAST = AW'(NUM_ALARMS - 1);
  if (NUM_ALARMS < 1 || NUM_ALARMS > 8 || TICK_DIV < 2 || RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > 255 ||
      SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_param
    $error("multi_alarm_clock_ctrl: parameter out of range");
  end
  typedef enum logic [2:0] {RUN, SET_TH, SET_TM, SET_AH, SET_AM, RING} state_e;
  state_e st_q, st_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d, hh_n, mm_n, ss_n;
  logic [NUM_ALARMS-1:0][5:0] ah_q, ah_d, am_q, am_d;
  logic [AW-1:0] sel_q, sel_d, hit_k;
  logic [7:0] rc_q, rc_d;
  logic run, tick, btn, adj, hit;
`ifdef MULTI_ALARM_SNOOZE_EN
  logic sn_v_q, sn_v_d;
  logic [5:0] sn_h_q, sn_h_d, sn_m_q, sn_m_d;
  logic [AW-1:0] sn_i_q, sn_i_d;
  logic [6:0] sm;
`endif
  function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] m, input logic inc);
    return inc ? ((v == m - 6'd1) ? 6'd0 : v + 6'd1) : ((v == 6'd0) ? m - 6'd1 : v - 6'd1);
  endfunction
  function automatic logic [7:0] bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction
  always_comb begin
    run = st_q == RUN || st_q == RING;
    tick = run && pre_q == PW'(TICK_DIV - 1);
    btn = btn_c_i | btn_l_i | btn_r_i | btn_u_i | btn_d_i;
    adj = btn_u_i | btn_d_i;
    ss_n = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
    mm_n = (ss_q == 6'd59) ? step(mm_q, 6'd60, 1'b1) : mm_q;
    hh_n = (ss_q == 6'd59 && mm_q == 6'd59) ? step(hh_q, 6'd24, 1'b1) : hh_q;
    hit = 1'b0;
    hit_k = '0;
    // descending scan so the lowest matching index is the one left standing
    for (int k = NUM_ALARMS - 1; k >= 0; k--)
      if (alarm_en_i[k] && ah_q[k] == hh_n && am_q[k] == mm_n) begin
        hit = 1'b1;
        hit_k = AW'(k);
      end
    st_d = st_q;
    sel_d = sel_q;
    rc_d = rc_q;
    ah_d = ah_q;
    am_d = am_q;
    pre_d = run ? (tick ? '0 : pre_q + 1'b1) : pre_q;
    hh_d = tick ? hh_n : hh_q;
    mm_d = tick ? mm_n : mm_q;
    ss_d = tick ? ss_n : ss_q;
`ifdef MULTI_ALARM_SNOOZE_EN
    sm = {1'b0, mm_q} + 7'(SNOOZE_MIN);
    sn_v_d = sn_v_q;
    sn_h_d = sn_h_q;
    sn_m_d = sn_m_q;
    sn_i_d = sn_i_q;
`endif
    case (st_q)
      RUN: if (btn_c_i) begin
        st_d = SET_TH;
        sel_d = '0;
`ifdef MULTI_ALARM_SNOOZE_EN
        sn_v_d = 1'b0;
`endif
      end else if (tick && ss_n == 6'd0 && !btn) begin
`ifdef MULTI_ALARM_SNOOZE_EN
        if (sn_v_q && sn_h_q == hh_n && sn_m_q == mm_n) begin
          st_d = RING;
          sel_d = sn_i_q;
          rc_d = '0;
          sn_v_d = 1'b0;
        end else
`endif
        if (hit) begin
          st_d = RING;
          sel_d = hit_k;
          rc_d = '0;
        end
      end
      RING: if (btn) begin
        st_d = RUN;
`ifdef MULTI_ALARM_SNOOZE_EN
        // snooze is measured from the current time while ringing
        if (!btn_c_i) begin
          sn_v_d = 1'b1;
          sn_h_d = (sm >= 7'd60) ? step(hh_q, 6'd24, 1'b1) : hh_q;
          sn_m_d = (sm >= 7'd60) ? 6'(sm - 7'd60) : sm[5:0];
          sn_i_d = sel_q;
        end
`endif
      end else if (tick) begin
        rc_d = rc_q + 8'd1;
        if (rc_d == 8'(RING_TIMEOUT_S)) begin
          st_d = RUN;
`ifdef MULTI_ALARM_SNOOZE_EN
          sn_v_d = 1'b0;
`endif
        end
      end
      default: if (btn_c_i) begin
        st_d = RUN;
        ss_d = '0;
        pre_d = '0;
      end else if (btn_l_i) begin
        st_d = (st_q == SET_TH) ? SET_AM : (st_q == SET_TM) ? SET_TH : (st_q == SET_AM) ? SET_AH :
               (sel_q == '0) ? SET_TM : SET_AM;
        sel_d = (st_q == SET_TH) ? LAST : (st_q == SET_AH && sel_q != '0) ? sel_q - 1'b1 : sel_q;
      end else if (btn_r_i) begin
        st_d = (st_q == SET_TH) ? SET_TM : (st_q == SET_TM) ? SET_AH : (st_q == SET_AH) ? SET_AM :
               (sel_q == LAST) ? SET_TH : SET_AH;
        sel_d = (st_q == SET_TM) ? '0 : (st_q == SET_AM && sel_q != LAST) ? sel_q + 1'b1 : sel_q;
      end else if (adj) begin
        hh_d = (st_q == SET_TH) ? step(hh_q, 6'd24, btn_u_i) : hh_q;
        mm_d = (st_q == SET_TM) ? step(mm_q, 6'd60, btn_u_i) : mm_q;
        ah_d[sel_q] = (st_q == SET_AH) ? step(ah_q[sel_q], 6'd24, btn_u_i) : ah_q[sel_q];
        am_d[sel_q] = (st_q == SET_AM) ? step(am_q[sel_q], 6'd60, btn_u_i) : am_q[sel_q];
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= RUN;
      pre_q <= '0;
      hh_q <= '0;
      mm_q <= '0;
      ss_q <= '0;
      ah_q <= '0;
      am_q <= '0;
      sel_q <= '0;
      rc_q <= '0;
      time_bcd_o <= '0;
      sec_bcd_o <= '0;
      disp_bcd_o <= '0;
      mode_led_o <= '0;
      ringing_o <= 1'b0;
      ring_blink_o <= 1'b0;
      sec_pulse_o <= 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
      sn_v_q <= 1'b0;
      sn_h_q <= '0;
      sn_m_q <= '0;
      sn_i_q <= '0;
`endif
    end else begin
      st_q <= st_d;
      pre_q <= pre_d;
      hh_q <= hh_d;
      mm_q <= mm_d;
      ss_q <= ss_d;
      ah_q <= ah_d;
      am_q <= am_d;
      sel_q <= sel_d;
      rc_q <= rc_d;
      time_bcd_o <= {bcd(hh_d), bcd(mm_d)};
      sec_bcd_o <= bcd(ss_d);
      disp_bcd_o <= (st_d == SET_AH || st_d == SET_AM) ? {bcd(ah_d[sel_d]), bcd(am_d[sel_d])} :
                    {bcd(hh_d), bcd(mm_d)};
      mode_led_o <= {st_d == SET_AM, st_d == SET_AH, st_d == SET_TM, st_d == SET_TH};
      ringing_o <= st_d == RING;
      ring_blink_o <= st_d == RING && !ss_d[0];
      sec_pulse_o <= tick;
`ifdef MULTI_ALARM_SNOOZE_EN
      sn_v_q <= sn_v_d;
      sn_h_q <= sn_h_d;
      sn_m_q <= sn_m_d;
      sn_i_q <= sn_i_d;
`endif
    end
  end
  assign alarm_sel_o = sel_q;
endmodule

// File: tb/tb_multi_alarm_clock_ctrl.sv
// tb_multi_alarm_clock_ctrl: directed stimulus with a seconds-of-day reference model checked every cycle
module tb_multi_alarm_clock_ctrl;
  localparam int N = 2, TD = 4, RT = 3, SM = 5, F = 2 + 2 * N;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, bc = 1'b0, bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
  logic [N-1:0] en = '0;
  logic [15:0] time_bcd_o, disp_bcd_o;
  logic [7:0] sec_bcd_o;
  logic [0:0] alarm_sel_o;
  logic [3:0] mode_led_o;
  logic ringing_o, ring_blink_o, sec_pulse_o;
  int checks = 0, failures = 0, n;
  always #5 clk = ~clk;
  multi_alarm_clock_ctrl #(.NUM_ALARMS(N), .TICK_DIV(TD), .RING_TIMEOUT_S(RT), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .rst(rst), .btn_c_i(bc), .btn_l_i(bl), .btn_r_i(br), .btn_u_i(bu), .btn_d_i(bd),
    .alarm_en_i(en), .time_bcd_o(time_bcd_o), .sec_bcd_o(sec_bcd_o), .disp_bcd_o(disp_bcd_o),
    .alarm_sel_o(alarm_sel_o), .mode_led_o(mode_led_o), .ringing_o(ringing_o),
    .ring_blink_o(ring_blink_o), .sec_pulse_o(sec_pulse_o));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // reference model: mode 0 run / 1 set / 2 ring, t = seconds of day, al = alarm minutes of day,
  // fp = position in the field ring (0 hours, 1 minutes, 2+2k alarm k hours, 3+2k alarm k minutes)
  bit mv = 1'b0;
  int mode = 0, fp = 0, t = 0, pre = 0, rc = 0, sel = 0, sv = 0, snm = 0, si = 0;
  int al[N];
  int e_time, e_sec, e_disp, e_sel, e_led, e_ring, e_blink, e_pulse;
  function automatic int bcd2(input int v);
    return (v / 10) * 16 + v % 10;
  endfunction
  always @(posedge clk) begin : model
    int nt, dl, a;
    bit tk, b;
    if (rst) begin
      mv = 1'b1;
      mode = 0; fp = 0; t = 0; pre = 0; rc = 0; sel = 0; sv = 0; tk = 1'b0;
      foreach (al[i]) al[i] = 0;
    end else begin
      tk = mode != 1 && pre == TD - 1;
      b = bc | bl | br | bu | bd;
      nt = tk ? (t + 1) % 86400 : t;
      if (mode != 1) pre = tk ? 0 : pre + 1;
      dl = bu ? 1 : -1;
      if (mode == 0) begin
        if (bc) begin
          mode = 1; fp = 0; sel = 0; sv = 0;
        end else if (tk && nt % 60 == 0 && !b) begin
          if (SNZ && sv != 0 && nt / 60 == snm) begin
            mode = 2; sel = si; sv = 0; rc = 0;
          end else
            for (int k = N - 1; k >= 0; k--)
              if (en[k] && al[k] == nt / 60) begin
                mode = 2; sel = k; rc = 0;
              end
        end
      end else if (mode == 2) begin
        if (b) begin
          mode = 0;
          if (SNZ && !bc) begin
            sv = 1; snm = (t / 60 + SM) % 1440; si = sel;
          end
        end else if (tk) begin
          rc++;
          if (rc >= RT) begin
            mode = 0; sv = 0;
          end
        end
      end else begin
        a = (fp - 2) / 2;
        if (bc) begin
          mode = 0; nt = nt - nt % 60; pre = 0;
        end else if (bl || br) begin
          fp = bl ? (fp + F - 1) % F : (fp + 1) % F;
          if (fp >= 2) sel = (fp - 2) / 2;
        end else if (bu || bd) begin
          if (fp == 0) nt = ((nt / 3600 + 24 + dl) % 24) * 3600 + nt % 3600;
          else if (fp == 1) nt = (nt / 3600) * 3600 + ((nt / 60 % 60 + 60 + dl) % 60) * 60 + nt % 60;
          else if (fp % 2 == 0) al[a] = ((al[a] / 60 + 24 + dl) % 24) * 60 + al[a] % 60;
          else al[a] = (al[a] / 60) * 60 + (al[a] % 60 + 60 + dl) % 60;
        end
      end
      t = nt;
    end
    e_time = bcd2(t / 3600) * 256 + bcd2(t / 60 % 60);
    e_sec = bcd2(t % 60);
    a = (fp - 2) / 2;
    e_disp = (mode == 1 && fp >= 2) ? bcd2(al[a] / 60) * 256 + bcd2(al[a] % 60) : e_time;
    e_sel = sel;
    e_led = (mode != 1) ? 0 : (fp < 2) ? (1 << fp) : (fp % 2 == 0) ? 4 : 8;
    e_ring = int'(mode == 2);
    e_blink = int'(mode == 2 && t % 2 == 0);
    e_pulse = int'(tk);
  end
  always @(negedge clk) if (mv) begin
    chk("time_bcd", int'(time_bcd_o), e_time);
    chk("sec_bcd", int'(sec_bcd_o), e_sec);
    chk("disp_bcd", int'(disp_bcd_o), e_disp);
    chk("alarm_sel", int'(alarm_sel_o), e_sel);
    chk("mode_led", int'(mode_led_o), e_led);
    chk("ringing", int'(ringing_o), e_ring);
    chk("ring_blink", int'(ring_blink_o), e_blink);
    chk("sec_pulse", int'(sec_pulse_o), e_pulse);
  end
  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask
  task automatic press(input int b);
    @(negedge clk);
    {bc, bl, br, bu, bd} = 5'b10000 >> b;
    @(negedge clk);
    {bc, bl, br, bu, bd} = '0;
  endtask
  task automatic wait_ring(input logic v, input int lim, output int c);
    c = 0;
    while (ringing_o !== v && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("ring_wait", int'(ringing_o), int'(v));
  endtask
  initial begin
    rst = 1'b1;
    idle(2);
    chk("rst_time", int'(time_bcd_o), 0);
    chk("rst_sec", int'(sec_bcd_o), 0);
    chk("rst_led", int'(mode_led_o), 0);
    chk("rst_pulse", int'(sec_pulse_o), 0);
    rst = 1'b0;
    idle(3);
    press(0);
    chk("led_th", int'(mode_led_o), 4'b0001);
    repeat (3) press(3);
    press(2);
    chk("led_tm", int'(mode_led_o), 4'b0010);
    press(4);
    press(0);
    chk("set_time", int'(time_bcd_o), 16'h0359);
    chk("set_sec", int'(sec_bcd_o), 0);
    chk("led_run", int'(mode_led_o), 0);
    idle(4);
    chk("pre_restart_pulse", int'(sec_pulse_o), 1);
    chk("pre_restart_sec", int'(sec_bcd_o), 8'h01);
    press(0);
    repeat (4) press(4);
    press(2);
    press(4);
    press(0);
    chk("preset_2358", int'(time_bcd_o), 16'h2358);
    n = 0;
    while (!(time_bcd_o == 16'h0 && sec_bcd_o == 8'h0 && sec_pulse_o) && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_hhmmss", int'({time_bcd_o, sec_bcd_o}), 0);
    chk("wrap_pulse", int'(sec_pulse_o), 1);
    press(0);
    repeat (3) press(2);
    press(3);
    chk("disp_alarm0", int'(disp_bcd_o), 16'h0001);
    repeat (2) press(2);
    press(3);
    press(0);
    en = 2'b11;
    wait_ring(1'b1, 300, n);
    chk("ring_sel_lowest", int'(alarm_sel_o), 0);
    chk("ring_time", int'(time_bcd_o), 16'h0001);
    chk("ring_sec", int'(sec_bcd_o), 0);
    n = 0;
    while (ringing_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ring_timeout_cycles", n, 12);
    press(0);
    repeat (3) press(2);
    press(3);
    press(0);
    wait_ring(1'b1, 300, n);
    chk("ring2_time", int'(time_bcd_o), 16'h0002);
    en = 2'b00;
    idle(2);
    chk("disarm_keeps_ring", int'(ringing_o), 1);
    press(3);
    chk("btn_dismiss", int'(ringing_o), 0);
    press(0);
    repeat (4) press(2);
    chk("disp_alarm1", int'(disp_bcd_o), 16'h0001);
    chk("led_ah", int'(mode_led_o), 4'b0100);
    chk("sel_alarm1", int'(alarm_sel_o), 1);
    press(4);
    chk("alarm1_hour_wrap", int'(disp_bcd_o), 16'h2301);
    press(0);
    press(0);
    rst = 1'b1;
    idle(1);
    chk("midset_rst_time", int'(time_bcd_o), 0);
    chk("midset_rst_led", int'(mode_led_o), 0);
    chk("midset_rst_disp", int'(disp_bcd_o), 0);
    rst = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
    idle(2);
    press(0);
    repeat (3) press(2);
    press(3);
    press(0);
    en = 2'b01;
    wait_ring(1'b1, 300, n);
    press(2);
    chk("snooze_release", int'(ringing_o), 0);
    wait_ring(1'b1, 1400, n);
    chk("snooze_time", int'(time_bcd_o), 16'h0006);
    chk("snooze_sel", int'(alarm_sel_o), 0);
    press(0);
    idle(400);
    chk("snooze_no_rering", int'(ringing_o), 0);
`endif
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
